// File: rtl/lcd_cnt_ctrl.sv
// lcd_cnt_ctrl: sequencer for a 3-digit dumb-LCD counter display.
// Holds a 000..999 BCD count with RUN / PAUSE / SET2 / SET1 / SET0 modes.
// Also provides leading-zero blanking, set-mode digit blink and the lcdcom
// AC drive.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous reset, active-high
//   btn_mode  1-cycle pulse, advance mode
//   btn_inc   1-cycle pulse, single-step (PAUSE) or selected digit +1 (SET*)
//   clr       synchronous clear of the count, mode unchanged
//   lcdcom    LCD common electrode square wave
//   bcd2..0   hundreds / tens / units digit, 0..9
//   digit_on  per-digit visible mask {d2,d1,d0} (combinational from state)
//   mode      RUN=0 PAUSE=1 SET2=2 SET1=3 SET0=4
//   wrap      1-cycle pulse when the count rolls 999->000

module lcd_cnt_ctrl #(
    parameter int unsigned COM_DIV   = 78,
    parameter int unsigned STEP_DIV  = 2048,
    parameter int unsigned BLINK_DIV = 1024,
    parameter bit          LZB       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       clr,
    output logic       lcdcom,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic [2:0] digit_on,
    output logic [2:0] mode,
    output logic       wrap
);

    localparam int unsigned COM_W   = (COM_DIV   > 1) ? $clog2(COM_DIV)   : 1;
    localparam int unsigned STEP_W  = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_PAUSE = 3'd1,
        ST_SET2  = 3'd2,
        ST_SET1  = 3'd3,
        ST_SET0  = 3'd4
    } mode_e;

    mode_e                state;
    mode_e                state_nxt;
    logic [COM_W-1:0]     com_cnt;
    logic [STEP_W-1:0]    step_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_phase;

    logic                 in_set;
    logic                 nxt_in_set;
    logic                 step_tc;
    logic                 inc_ok;
    logic                 do_inc;
    logic                 set_inc;
    logic                 is_999;
    logic [3:0]           inc2, inc1, inc0;

    assign mode = state;

    // Wrap a single decimal digit 9->0 without carry.
    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Next mode on btn_mode; any unreachable encoding falls back to RUN.
    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN:   state_nxt = btn_mode ? ST_PAUSE : ST_RUN;
            ST_PAUSE: state_nxt = btn_mode ? ST_SET2  : ST_PAUSE;
            ST_SET2:  state_nxt = btn_mode ? ST_SET1  : ST_SET2;
            ST_SET1:  state_nxt = btn_mode ? ST_SET0  : ST_SET1;
            ST_SET0:  state_nxt = btn_mode ? ST_RUN   : ST_SET0;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Event qualification: clr beats btn_mode beats btn_inc / step.
    always_comb begin
        in_set     = (state == ST_SET2) || (state == ST_SET1) || (state == ST_SET0);
        nxt_in_set = (state_nxt == ST_SET2) || (state_nxt == ST_SET1) ||
                     (state_nxt == ST_SET0);
        step_tc    = (state == ST_RUN) && (step_cnt == STEP_W'(STEP_DIV - 1));
        inc_ok     = btn_inc && !clr && !btn_mode;
        do_inc     = (step_tc && !clr && !btn_mode) || ((state == ST_PAUSE) && inc_ok);
        set_inc    = in_set && inc_ok;
        is_999     = (bcd2 == 4'd9) && (bcd1 == 4'd9) && (bcd0 == 4'd9);
    end

    // Decimal ripple increment of the whole count.
    always_comb begin
        inc0 = bcd0 + 4'd1;
        inc1 = bcd1;
        inc2 = bcd2;
        if (bcd0 >= 4'd9) begin
            inc0 = 4'd0;
            inc1 = bcd1 + 4'd1;
            if (bcd1 >= 4'd9) begin
                inc1 = 4'd0;
                inc2 = digit_inc(bcd2);
            end
        end
    end

    // All sequential state.
    always_ff @(posedge clk) begin
        if (rst) begin
            com_cnt     <= '0;
            lcdcom      <= 1'b0;
            state       <= ST_RUN;
            step_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            bcd2        <= 4'd0;
            bcd1        <= 4'd0;
            bcd0        <= 4'd0;
            wrap        <= 1'b0;
        end else begin
            // lcdcom runs free of mode and clr.
            if (com_cnt == COM_W'(COM_DIV - 1)) begin
                com_cnt <= '0;
                lcdcom  <= ~lcdcom;
            end else begin
                com_cnt <= com_cnt + COM_W'(1);
            end

            state <= state_nxt;

            // Step prescaler only advances while staying in RUN.
            if ((state == ST_RUN) && (state_nxt == ST_RUN) && !clr && !step_tc) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end else begin
                step_cnt <= '0;
            end

            // Blink restarts visible on any mode change or accepted digit edit.
            if (!nxt_in_set || btn_mode || set_inc) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            wrap <= do_inc && is_999;

            if (clr) begin
                bcd2 <= 4'd0;
                bcd1 <= 4'd0;
                bcd0 <= 4'd0;
            end else if (do_inc) begin
                bcd2 <= inc2;
                bcd1 <= inc1;
                bcd0 <= inc0;
            end else if (set_inc) begin
                case (state)
                    ST_SET2: bcd2 <= digit_inc(bcd2);
                    ST_SET1: bcd1 <= digit_inc(bcd1);
                    ST_SET0: bcd0 <= digit_inc(bcd0);
                    default: ;
                endcase
            end
        end
    end

    // Visible mask: blink the selected digit in SET*, else leading-zero blanking.
    always_comb begin
        digit_on = 3'b111;
        case (state)
            ST_SET2: digit_on[2] = ~blink_phase;
            ST_SET1: digit_on[1] = ~blink_phase;
            ST_SET0: digit_on[0] = ~blink_phase;
            default: begin
                if (LZB) begin
                    digit_on[2] = (bcd2 != 4'd0);
                    digit_on[1] = (bcd2 != 4'd0) || (bcd1 != 4'd0);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_cnt_ctrl.sv
module tb_lcd_cnt_ctrl;

    localparam int COM_DIV   = 3;
    localparam int STEP_DIV  = 4;
    localparam int BLINK_DIV = 5;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic       clr;
    logic       lcdcom;
    logic [3:0] bcd2, bcd1, bcd0;
    logic [2:0] digit_on;
    logic [2:0] mode;
    logic       wrap;

    int vectors;
    int miscompares;

    // Reference model state: count as an integer, ages in cycles.
    int m_cnt;
    int m_mode;
    int m_run_age;
    int m_blink_age;
    int m_com_age;
    int m_wrap;

    lcd_cnt_ctrl #(
        .COM_DIV  (COM_DIV),
        .STEP_DIV (STEP_DIV),
        .BLINK_DIV(BLINK_DIV),
        .LZB      (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .clr     (clr),
        .lcdcom  (lcdcom),
        .bcd2    (bcd2),
        .bcd1    (bcd1),
        .bcd0    (bcd0),
        .digit_on(digit_on),
        .mode    (mode),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_lcdcom();
        return (m_com_age / COM_DIV) % 2;
    endfunction

    function automatic logic [2:0] exp_don();
        logic [2:0] d;
        int h, t;
        d = 3'b111;
        h = m_cnt / 100;
        t = (m_cnt / 10) % 10;
        if (m_mode >= 2) begin
            if (((m_blink_age / BLINK_DIV) % 2) == 1) d[4 - m_mode] = 1'b0;
        end else begin
            d[2] = (h != 0);
            d[1] = (h != 0) || (t != 0);
        end
        return d;
    endfunction

    task automatic model_update(input logic r, input logic c, input logic m, input logic i);
        int old_mode, d2, d1, d0;
        bit stepped;
        if (r) begin
            m_cnt = 0; m_mode = 0; m_run_age = 0; m_blink_age = 0; m_com_age = 0; m_wrap = 0;
            return;
        end
        m_com_age++;
        m_wrap   = 0;
        old_mode = m_mode;
        if (m) m_mode = (m_mode + 1) % 5;
        stepped = 0;
        if (c || old_mode != 0 || m_mode != 0) begin
            m_run_age = 0;
        end else begin
            m_run_age++;
            if (m_run_age == STEP_DIV) begin
                m_run_age = 0;
                stepped   = 1;
            end
        end
        if (c) begin
            m_cnt = 0;
        end else if (!m) begin
            if (stepped || (old_mode == 1 && i)) begin
                m_wrap = (m_cnt == 999) ? 1 : 0;
                m_cnt  = (m_cnt + 1) % 1000;
            end else if (old_mode >= 2 && i) begin
                d2 = m_cnt / 100; d1 = (m_cnt / 10) % 10; d0 = m_cnt % 10;
                if (old_mode == 2) d2 = (d2 + 1) % 10;
                if (old_mode == 3) d1 = (d1 + 1) % 10;
                if (old_mode == 4) d0 = (d0 + 1) % 10;
                m_cnt = d2 * 100 + d1 * 10 + d0;
            end
        end
        if (m_mode < 2 || m || (i && !c)) m_blink_age = 0;
        else m_blink_age++;
    endtask

    // Apply one cycle of inputs, advance the model, return at the next negedge.
    task automatic step(input logic r, input logic c, input logic m, input logic i);
        rst = r; clr = c; btn_mode = m; btn_inc = i;
        @(posedge clk);
        model_update(r, c, m, i);
        @(negedge clk);
        rst = 1'b0; clr = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reset then load a value through SET2/SET1/SET0, ending in SET0.
    task automatic preload(input int h, input int t, input int u);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        press_inc(h);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        press_inc(t);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        press_inc(u);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({lcdcom, bcd2, bcd1, bcd0, digit_on, mode, wrap} !== {1'b0, 12'h000, 3'b001, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got lcdcom=%b bcd=%h%h%h don=%b mode=%0d wrap=%b, exp 0 000 001 0 0",
                     lcdcom, bcd2, bcd1, bcd0, digit_on, mode, wrap);
        end
    endtask

    task automatic test_run_count();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            idle(1);
            vectors++;
            if (lcdcom !== 1'((i / 3) % 2)) begin
                miscompares++;
                $display("FAIL run_lcdcom cycle %0d: got %b exp %b", i, lcdcom, 1'((i / 3) % 2));
            end
        end
        vectors++;
        if ({bcd2, bcd1, bcd0, digit_on, mode} !== {12'h010, 3'b011, 3'd0}) begin
            miscompares++;
            $display("FAIL run_count: got bcd=%h%h%h don=%b mode=%0d, exp 010 011 0",
                     bcd2, bcd1, bcd0, digit_on, mode);
        end
    endtask

    task automatic test_wrap();
        preload(9, 9, 8);
        vectors++;
        if ({bcd2, bcd1, bcd0, mode} !== {12'h998, 3'd4}) begin
            miscompares++;
            $display("FAIL wrap_preload: got bcd=%h%h%h mode=%0d, exp 998 4", bcd2, bcd1, bcd0, mode);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            idle(1);
            vectors++;
            if (wrap !== (i == 8)) begin
                miscompares++;
                $display("FAIL wrap_pulse cycle %0d: got %b exp %b", i, wrap, (i == 8));
            end
            if (i == 4) begin
                vectors++;
                if ({bcd2, bcd1, bcd0} !== 12'h999) begin
                    miscompares++;
                    $display("FAIL wrap_999: got %h%h%h exp 999", bcd2, bcd1, bcd0);
                end
            end
            if (i == 8) begin
                vectors++;
                if ({bcd2, bcd1, bcd0, digit_on} !== {12'h000, 3'b001}) begin
                    miscompares++;
                    $display("FAIL wrap_000: got %h%h%h don=%b exp 000 001", bcd2, bcd1, bcd0, digit_on);
                end
            end
        end
    endtask

    task automatic test_pause();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({bcd2, bcd1, bcd0, mode} !== {12'h005, 3'd1}) begin
            miscompares++;
            $display("FAIL pause_enter: got bcd=%h%h%h mode=%0d exp 005 1", bcd2, bcd1, bcd0, mode);
        end
        press_inc(6);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) idle(1);
            vectors++;
            if ({bcd2, bcd1, bcd0} !== 12'h011) begin
                miscompares++;
                $display("FAIL pause_hold %0d: got %h%h%h exp 011", i, bcd2, bcd1, bcd0);
            end
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            vectors++;
            if ({bcd2, bcd1, bcd0} !== ((i == 4) ? 12'h012 : 12'h011)) begin
                miscompares++;
                $display("FAIL pause_resume %0d: got %h%h%h", i, bcd2, bcd1, bcd0);
            end
        end
    endtask

    task automatic test_set_blink();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
        press_inc(9);
        vectors++;
        if ({bcd2, bcd1, bcd0, mode} !== {12'h090, 3'd3}) begin
            miscompares++;
            $display("FAIL set1_load: got bcd=%h%h%h mode=%0d exp 090 3", bcd2, bcd1, bcd0, mode);
        end
        press_inc(1);
        vectors++;
        if ({bcd2, bcd1, bcd0, digit_on} !== {12'h000, 3'b111}) begin
            miscompares++;
            $display("FAIL set1_nocarry: got %h%h%h don=%b exp 000 111", bcd2, bcd1, bcd0, digit_on);
        end
        for (int i = 1; i <= 10; i++) begin
            idle(1);
            vectors++;
            if (digit_on !== ((((i / 5) % 2) == 0) ? 3'b111 : 3'b101)) begin
                miscompares++;
                $display("FAIL blink cycle %0d: got %b", i, digit_on);
            end
        end
    endtask

    task automatic test_priority();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        press_inc(3);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({bcd2, bcd1, bcd0, mode} !== {12'h003, 3'd2}) begin
            miscompares++;
            $display("FAIL mode_beats_inc: got bcd=%h%h%h mode=%0d exp 003 2", bcd2, bcd1, bcd0, mode);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(7);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({bcd2, bcd1, bcd0, wrap} !== {12'h000, 1'b0}) begin
            miscompares++;
            $display("FAIL clr_on_step: got %h%h%h wrap=%b exp 000 0", bcd2, bcd1, bcd0, wrap);
        end
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            vectors++;
            if ({bcd2, bcd1, bcd0} !== ((i == 4) ? 12'h001 : 12'h000)) begin
                miscompares++;
                $display("FAIL clr_restart %0d: got %h%h%h", i, bcd2, bcd1, bcd0);
            end
        end
    endtask

    task automatic test_rst_in_set();
        preload(5, 3, 7);
        vectors++;
        if ({bcd2, bcd1, bcd0, mode} !== {12'h537, 3'd4}) begin
            miscompares++;
            $display("FAIL set0_537: got bcd=%h%h%h mode=%0d exp 537 4", bcd2, bcd1, bcd0, mode);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({lcdcom, bcd2, bcd1, bcd0, digit_on, mode} !== {1'b0, 12'h000, 3'b001, 3'd0}) begin
            miscompares++;
            $display("FAIL rst_in_set: got lcdcom=%b bcd=%h%h%h don=%b mode=%0d",
                     lcdcom, bcd2, bcd1, bcd0, digit_on, mode);
        end
    endtask

    task automatic test_random();
        logic r, c, m, i;
        logic [19:0] expv;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 599) == 0);
            c = ($urandom_range(0, 99) == 0);
            m = ($urandom_range(0, 11) == 0);
            i = ($urandom_range(0, 4) == 0);
            step(r, c, m, i);
            expv = {1'(exp_lcdcom()), 4'(m_cnt / 100), 4'((m_cnt / 10) % 10), 4'(m_cnt % 10),
                    exp_don(), 3'(m_mode), 1'(m_wrap)};
            vectors++;
            if ({lcdcom, bcd2, bcd1, bcd0, digit_on, mode, wrap} !== expv) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %h exp %h", n,
                         {lcdcom, bcd2, bcd1, bcd0, digit_on, mode, wrap}, expv);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_cnt = 0; m_mode = 0; m_run_age = 0; m_blink_age = 0; m_com_age = 0; m_wrap = 0;
        rst = 1'b1; clr = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        test_reset();
        test_run_count();
        test_wrap();
        test_pause();
        test_set_blink();
        test_priority();
        test_rst_in_set();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
